// File: rtl/nasti_mem_slave_if.sv
// NASTI (AXI4) channel bundle: AW/W/B/AR/R signal groups with master and slave views.
// Shared by the buffer/crossbar path and the endpoints that terminate it.
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_mem_slave.sv
// NASTI responder backed by a byte-enabled dual-port synchronous RAM; independent read/write engines.
// Optional NASTI_MEM_SLAVE_RANGE_CHECK_EN: out-of-window beats are dropped/zeroed and answered SLVERR.
module nasti_mem_slave #(
  parameter int          ID_WIDTH   = 1,
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 64,
  parameter int          USER_WIDTH = 1,
  parameter int          MEM_BYTES  = 4096,
  parameter int unsigned BASE       = 0
) (
  input logic         clk,
  input logic         rstn,
  nasti_channel.slave s
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int WORDS  = MEM_BYTES / NBYTES;
  localparam int IDX_W  = $clog2(WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE);
  localparam logic [ADDR_WIDTH-1:0] SPAN_A = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
`ifdef NASTI_MEM_SLAVE_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_A) >> LSB);
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return RANGE_EN && ((a - BASE_A) >= SPAN_A);
  endfunction

  function automatic logic illegal(input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'(LSB));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] b, mask;
    b    = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * b) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + b) & mask);
      default: return a + b;
    endcase
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rd_q;

  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_ill, w_err;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_ill;

  logic                  w_fire, mem_we, w_last_beat, w_beat_err;
  logic                  ar_fire, rd_en, rd_zero;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign w_fire      = (w_state == W_DATA) && s.w_valid;
  assign w_last_beat = (w_beat == w_len);
  assign w_beat_err  = (s.w_last != w_last_beat) || out_of_range(w_addr);
  assign mem_we      = w_fire && !w_ill && !out_of_range(w_addr);

  // The read port is shared by the AR capture and the streaming beat advance.
  assign ar_fire = (r_state == R_IDLE) && s.ar_valid;
  assign rd_en   = ar_fire || ((r_state == R_DATA) && s.r_ready && !s.r_last);
  assign rd_addr = (r_state == R_IDLE) ? s.ar_addr : next_addr(r_addr, r_len, r_size, r_burst);
  assign rd_zero = ((r_state == R_IDLE) ? illegal(s.ar_size, s.ar_burst) : r_ill) ||
                   out_of_range(rd_addr);
  assign s.r_data = rd_q;

  // RAM: byte-enabled write port, registered read port (read-first on collision).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (s.w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= s.w_data[8*i +: 8];
      end
    end
    if (rd_en) rd_q <= rd_zero ? '0 : mem[word_idx(rd_addr)];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state    <= W_IDLE;
      s.aw_ready <= 1'b1;
      s.w_ready  <= 1'b0;
      s.b_valid  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s.aw_valid) begin
          w_addr     <= s.aw_addr;
          w_len      <= s.aw_len;
          w_size     <= s.aw_size;
          w_burst    <= s.aw_burst;
          w_ill      <= illegal(s.aw_size, s.aw_burst);
          w_err      <= 1'b0;
          w_beat     <= 8'd0;
          s.b_id     <= s.aw_id;
          s.b_user   <= s.aw_user;
          s.aw_ready <= 1'b0;
          s.w_ready  <= 1'b1;
          w_state    <= W_DATA;
        end
        W_DATA: if (s.w_valid) begin
          w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
          w_beat <= w_beat + 8'd1;
          w_err  <= w_err | w_beat_err;
          if (w_last_beat) begin
            s.w_ready <= 1'b0;
            s.b_valid <= 1'b1;
            s.b_resp  <= (w_ill || w_err || w_beat_err) ? SLVERR : OKAY;
            w_state   <= W_RESP;
          end
        end
        W_RESP: if (s.b_ready) begin
          s.b_valid  <= 1'b0;
          s.aw_ready <= 1'b1;
          w_state    <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= R_IDLE;
      s.ar_ready <= 1'b1;
      s.r_valid  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (s.ar_valid) begin
          r_addr     <= s.ar_addr;
          r_len      <= s.ar_len;
          r_size     <= s.ar_size;
          r_burst    <= s.ar_burst;
          r_ill      <= illegal(s.ar_size, s.ar_burst);
          r_beat     <= 8'd0;
          s.r_id     <= s.ar_id;
          s.r_user   <= s.ar_user;
          s.r_last   <= (s.ar_len == 8'd0);
          s.r_resp   <= rd_zero ? SLVERR : OKAY;
          s.ar_ready <= 1'b0;
          s.r_valid  <= 1'b1;
          r_state    <= R_DATA;
        end
        R_DATA: if (s.r_ready) begin
          if (s.r_last) begin
            s.r_valid  <= 1'b0;
            s.ar_ready <= 1'b1;
            r_state    <= R_IDLE;
          end else begin
            r_addr   <= rd_addr;
            r_beat   <= r_beat + 8'd1;
            s.r_last <= ((r_beat + 8'd1) == r_len);
            s.r_resp <= rd_zero ? SLVERR : OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{s.aw_lock, s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region, s.w_user,
                             s.ar_lock, s.ar_cache, s.ar_prot, s.ar_qos, s.ar_region};
endmodule
